// File: rtl/uart_rx_frame_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - parity mode encodings
//   - receive FSM state encoding
//   - cycles_per_bit(): bit period in clk cycles
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_rx_frame_sampler.sv
// uart_rx_sampler: line conditioning and bit recovery for the UART receiver.
//   clk, reset : system clock, async active-high reset
//   rxd        : raw serial input (asynchronous)
//   clear      : restart the bit timer at 0 (start edge seen)
//   rxd_s      : synchronised line
//   fall_edge  : rxd_s went 1 -> 0 this cycle
//   bit_done   : strobe on the cycle the mid-bit vote resolves
//   bit_val    : majority of the three mid-bit samples (valid with bit_done)
module uart_rx_sampler #(
    parameter int CYCLES_PER_BIT = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    input  logic clear,
    output logic rxd_s,
    output logic fall_edge,
    output logic bit_done,
    output logic bit_val
);

    localparam int TW = $clog2(CYCLES_PER_BIT);
    localparam int M  = CYCLES_PER_BIT / 2;
    localparam logic [TW-1:0] T_LAST = TW'(CYCLES_PER_BIT - 1);
    localparam logic [TW-1:0] T_S0   = TW'(M - 1);
    localparam logic [TW-1:0] T_S1   = TW'(M);
    localparam logic [TW-1:0] T_S2   = TW'(M + 1);

    logic          sync1, sync2, rxd_q;
    logic [TW-1:0] timer;
    logic          s0, s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            rxd_q <= 1'b1;
            timer <= '0;
            s0    <= 1'b1;
            s1    <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            rxd_q <= sync2;
            if (clear || timer == T_LAST)
                timer <= '0;
            else
                timer <= timer + 1'b1;
            if (timer == T_S0) s0 <= sync2;
            if (timer == T_S1) s1 <= sync2;
        end
    end

    assign rxd_s     = sync2;
    assign fall_edge = rxd_q & ~sync2;
    // Third sample is the live line on the resolve cycle, so the vote is
    // available without an extra register stage.
    assign bit_done  = (timer == T_S2);
    assign bit_val   = (s0 & s1) | (s0 & sync2) | (s1 & sync2);

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with ready/valid output.
//   clk, reset      : system clock, async active-high reset
//   uart_rxd        : serial input
//   uart_rx_en      : receive enable (low abandons any frame in progress)
//   uart_rx_ready   : consumer accepts the held word
//   uart_rx_valid   : word + status held for the consumer
//   uart_rx_data    : received word, first bit on the line at LSB
//   uart_rx_perr    : parity error
//   uart_rx_ferr    : a stop bit sampled 0
//   uart_rx_break   : data, parity and stop all 0
//   uart_rx_overrun : 1-cycle pulse when a finished frame is dropped
//   uart_rx_busy    : FSM outside IDLE
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    input  logic                    uart_rx_ready,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_perr,
    output logic                    uart_rx_ferr,
    output logic                    uart_rx_break,
    output logic                    uart_rx_overrun,
    output logic                    uart_rx_busy
);

    localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam logic [3:0] LAST_DATA = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic rxd_s, fall_edge, bit_done, bit_val, timer_clr;

    uart_rx_sampler #(.CYCLES_PER_BIT(CPB)) u_sampler (
        .clk       (clk),
        .reset     (reset),
        .rxd       (uart_rxd),
        .clear     (timer_clr),
        .rxd_s     (rxd_s),
        .fall_edge (fall_edge),
        .bit_done  (bit_done),
        .bit_val   (bit_val)
    );

    state_t                  state, next_state;
    logic [3:0]              bit_cnt;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    perr_q, ferr_q, any_one;
    logic                    frame_done, ferr_now, brk_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        timer_clr  = 1'b0;
        frame_done = 1'b0;
        // Status as it stands with the current (last) stop bit folded in.
        ferr_now   = ferr_q | ~bit_val;
        brk_now    = ~any_one & ~bit_val;
        if (!uart_rx_en) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (fall_edge) begin
                    timer_clr  = 1'b1;
                    next_state = ST_START;
                end
                ST_START: if (bit_done)
                    next_state = bit_val ? ST_IDLE : ST_DATA;
                ST_DATA: if (bit_done && bit_cnt == LAST_DATA)
                    next_state = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                ST_PARITY: if (bit_done)
                    next_state = ST_STOP;
                ST_STOP: if (bit_done && bit_cnt == LAST_STOP) begin
                    frame_done = 1'b1;
                    // Break always implies ferr, so one test covers both.
                    next_state = ferr_now ? ST_WAIT_IDLE : ST_IDLE;
                end
                ST_WAIT_IDLE: if (rxd_s)
                    next_state = ST_IDLE;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Frame datapath: bit counter restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            any_one <= 1'b0;
        end else begin
            if (next_state != state) bit_cnt <= '0;
            else if (bit_done)       bit_cnt <= bit_cnt + 1'b1;
            if (state == ST_IDLE) begin
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                any_one <= 1'b0;
            end
            if (bit_done) begin
                case (state)
                    ST_DATA: begin
                        shreg   <= {bit_val, shreg[PAYLOAD_BITS-1:1]};
                        any_one <= any_one | bit_val;
                    end
                    ST_PARITY: begin
                        perr_q  <= (PARITY == PARITY_ODD) ? ~(^shreg ^ bit_val)
                                                          :  (^shreg ^ bit_val);
                        any_one <= any_one | bit_val;
                    end
                    ST_STOP: begin
                        ferr_q  <= ferr_q | ~bit_val;
                        any_one <= any_one | bit_val;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output holding register with ready/valid handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_rx_valid   <= 1'b0;
            uart_rx_data    <= '0;
            uart_rx_perr    <= 1'b0;
            uart_rx_ferr    <= 1'b0;
            uart_rx_break   <= 1'b0;
            uart_rx_overrun <= 1'b0;
        end else begin
            uart_rx_overrun <= 1'b0;
            if (frame_done) begin
                if (!uart_rx_valid || uart_rx_ready) begin
                    uart_rx_valid <= 1'b1;
                    uart_rx_data  <= shreg;
                    uart_rx_perr  <= perr_q;
                    uart_rx_ferr  <= ferr_now;
                    uart_rx_break <= brk_now;
                end else begin
                    uart_rx_overrun <= 1'b1;
                end
            end else if (uart_rx_valid && uart_rx_ready) begin
                uart_rx_valid <= 1'b0;
            end
        end
    end

    assign uart_rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench: three receivers at 50 cycles/bit (8N1, 8E1, 8N2).
module tb_uart_rx_frame;

    localparam int CPB = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       ready = 1'b1;
    logic       rxd   [3];
    logic       valid [3];
    logic [7:0] data  [3];
    logic       perr  [3];
    logic       ferr  [3];
    logic       brk   [3];
    logic       ovr   [3];
    logic       busy  [3];

    int         vcnt [3];
    int         ocnt [3];
    logic [7:0] cdata [3];
    logic       cperr [3];
    logic       cferr [3];
    logic       cbrk  [3];
    logic       cbusy [3];

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    uart_rx_frame #(.BIT_RATE(1000000), .CLK_HZ(50000000), .PAYLOAD_BITS(8),
                    .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .uart_rxd(rxd[0]), .uart_rx_en(en),
        .uart_rx_ready(ready), .uart_rx_valid(valid[0]), .uart_rx_data(data[0]),
        .uart_rx_perr(perr[0]), .uart_rx_ferr(ferr[0]), .uart_rx_break(brk[0]),
        .uart_rx_overrun(ovr[0]), .uart_rx_busy(busy[0]));

    uart_rx_frame #(.BIT_RATE(1000000), .CLK_HZ(50000000), .PAYLOAD_BITS(8),
                    .PARITY(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .reset(reset), .uart_rxd(rxd[1]), .uart_rx_en(en),
        .uart_rx_ready(ready), .uart_rx_valid(valid[1]), .uart_rx_data(data[1]),
        .uart_rx_perr(perr[1]), .uart_rx_ferr(ferr[1]), .uart_rx_break(brk[1]),
        .uart_rx_overrun(ovr[1]), .uart_rx_busy(busy[1]));

    uart_rx_frame #(.BIT_RATE(1000000), .CLK_HZ(50000000), .PAYLOAD_BITS(8),
                    .PARITY(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .reset(reset), .uart_rxd(rxd[2]), .uart_rx_en(en),
        .uart_rx_ready(ready), .uart_rx_valid(valid[2]), .uart_rx_data(data[2]),
        .uart_rx_perr(perr[2]), .uart_rx_ferr(ferr[2]), .uart_rx_break(brk[2]),
        .uart_rx_overrun(ovr[2]), .uart_rx_busy(busy[2]));

    // Record every accepted word and every overrun cycle.
    initial begin
        for (int k = 0; k < 3; k++) begin
            rxd[k] = 1'b1; vcnt[k] = 0; ocnt[k] = 0;
            cdata[k] = '0; cperr[k] = 0; cferr[k] = 0; cbrk[k] = 0; cbusy[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (valid[k] && ready) begin
                vcnt[k]  <= vcnt[k] + 1;
                cdata[k] <= data[k];
                cperr[k] <= perr[k];
                cferr[k] <= ferr[k];
                cbrk[k]  <= brk[k];
                cbusy[k] <= busy[k];
            end
            if (ovr[k]) ocnt[k] <= ocnt[k] + 1;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // par < 0: no parity bit; stops[i] is the i-th stop bit.
    task automatic send_frame(input int sel, input logic [7:0] d, input int par,
                              input logic [1:0] stops, input int nstop);
        rxd[sel] = 1'b0; wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd[sel] = d[i]; wait_cyc(CPB);
        end
        if (par >= 0) begin
            rxd[sel] = par[0]; wait_cyc(CPB);
        end
        for (int i = 0; i < nstop; i++) begin
            rxd[sel] = stops[i]; wait_cyc(CPB);
        end
        rxd[sel] = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_cyc(4);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({valid[k], data[k], perr[k], ferr[k], brk[k], ovr[k], busy[k]} !== 14'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %b want 0", k,
                         {valid[k], data[k], perr[k], ferr[k], brk[k], ovr[k], busy[k]});
            end
        end
        reset = 1'b0;
        wait_cyc(10);
    endtask

    task automatic test_clean;
        int v0;
        v0 = vcnt[0];
        send_frame(0, 8'hA5, -1, 2'b11, 1);
        wait_cyc(20);
        checks++;
        if (vcnt[0] !== v0 + 1) begin errors++; $display("FAIL clean_count got %0d want %0d", vcnt[0], v0 + 1); end
        checks++;
        if (cdata[0] !== 8'hA5) begin errors++; $display("FAIL clean_data got %h want a5", cdata[0]); end
        checks++;
        if ({cperr[0], cferr[0], cbrk[0]} !== 3'b000) begin
            errors++; $display("FAIL clean_status got %b want 000", {cperr[0], cferr[0], cbrk[0]});
        end
        checks++;
        if (cbusy[0] !== 1'b0) begin errors++; $display("FAIL clean_no_wait_idle busy got %b want 0", cbusy[0]); end
    endtask

    task automatic test_parity;
        send_frame(1, 8'h07, 0, 2'b11, 1);
        wait_cyc(20);
        checks++;
        if (cperr[1] !== 1'b1) begin errors++; $display("FAIL parity_bad perr got %b want 1", cperr[1]); end
        checks++;
        if (cdata[1] !== 8'h07) begin errors++; $display("FAIL parity_bad data got %h want 07", cdata[1]); end
        send_frame(1, 8'h07, 1, 2'b11, 1);
        wait_cyc(20);
        checks++;
        if (cperr[1] !== 1'b0) begin errors++; $display("FAIL parity_good perr got %b want 0", cperr[1]); end
        checks++;
        if ({vcnt[1], cdata[1]} !== {32'd2, 8'h07}) begin
            errors++; $display("FAIL parity_count got %0d/%h want 2/07", vcnt[1], cdata[1]);
        end
    endtask

    task automatic test_break;
        int v0;
        v0 = vcnt[0];
        rxd[0] = 1'b0;
        wait_cyc(15 * CPB);
        checks++;
        if (vcnt[0] !== v0 + 1) begin errors++; $display("FAIL break_count got %0d want %0d", vcnt[0], v0 + 1); end
        checks++;
        if ({cdata[0], cbrk[0], cferr[0]} !== {8'h00, 2'b11}) begin
            errors++; $display("FAIL break_status got %h/%b%b want 00/11", cdata[0], cbrk[0], cferr[0]);
        end
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL break_hold busy got %b want 1", busy[0]); end
        rxd[0] = 1'b1;
        wait_cyc(2 * CPB);
        checks++;
        if ({vcnt[0] == v0 + 1, busy[0]} !== 2'b10) begin
            errors++; $display("FAIL break_release cnt %0d busy %b want %0d/0", vcnt[0], busy[0], v0 + 1);
        end
        send_frame(0, 8'h5A, -1, 2'b11, 1);
        wait_cyc(20);
        checks++;
        if ({vcnt[0] == v0 + 2, cdata[0], cbrk[0], cferr[0]} !== {1'b1, 8'h5A, 2'b00}) begin
            errors++; $display("FAIL break_next cnt %0d data %h brk %b ferr %b want %0d/5a/0/0",
                               vcnt[0], cdata[0], cbrk[0], cferr[0], v0 + 2);
        end
    endtask

    task automatic test_glitch;
        int v0;
        v0 = vcnt[0];
        rxd[0] = 1'b0;
        wait_cyc(10);
        rxd[0] = 1'b1;
        wait_cyc(5);
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL glitch_start busy got %b want 1", busy[0]); end
        wait_cyc(2 * CPB);
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL glitch_reject busy got %b want 0", busy[0]); end
        checks++;
        if (vcnt[0] !== v0) begin errors++; $display("FAIL glitch_no_valid got %0d want %0d", vcnt[0], v0); end
    endtask

    task automatic test_enable;
        int v0;
        v0 = vcnt[0];
        en = 1'b0;
        send_frame(0, 8'h33, -1, 2'b11, 1);
        wait_cyc(20);
        checks++;
        if ({vcnt[0] == v0, busy[0]} !== 2'b10) begin
            errors++; $display("FAIL enable_off cnt %0d busy %b want %0d/0", vcnt[0], busy[0], v0);
        end
        en = 1'b1;
        wait_cyc(10);
    endtask

    task automatic test_overrun;
        int v0, o0;
        v0 = vcnt[0];
        o0 = ocnt[0];
        ready = 1'b0;
        send_frame(0, 8'h11, -1, 2'b11, 1);
        send_frame(0, 8'h22, -1, 2'b11, 1);
        wait_cyc(20);
        checks++;
        if ({valid[0], data[0]} !== {1'b1, 8'h11}) begin
            errors++; $display("FAIL overrun_hold valid %b data %h want 1/11", valid[0], data[0]);
        end
        checks++;
        if (ocnt[0] !== o0 + 1) begin errors++; $display("FAIL overrun_pulse got %0d want %0d", ocnt[0], o0 + 1); end
        ready = 1'b1;
        wait_cyc(3);
        checks++;
        if (valid[0] !== 1'b0) begin errors++; $display("FAIL overrun_clear valid got %b want 0", valid[0]); end
        checks++;
        if ({vcnt[0] == v0 + 1, cdata[0]} !== {1'b1, 8'h11}) begin
            errors++; $display("FAIL overrun_accept cnt %0d data %h want %0d/11", vcnt[0], cdata[0], v0 + 1);
        end
    endtask

    task automatic test_two_stop;
        int v0;
        send_frame(2, 8'h3C, -1, 2'b01, 2);
        wait_cyc(20);
        checks++;
        if ({cdata[2], cferr[2], cbrk[2]} !== {8'h3C, 2'b10}) begin
            errors++; $display("FAIL two_stop got %h/%b%b want 3c/10", cdata[2], cferr[2], cbrk[2]);
        end
        wait_cyc(CPB);
        v0 = vcnt[2];
        rxd[2] = 1'b0;
        wait_cyc(3 * CPB);
        checks++;
        if (busy[2] !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b want 1", busy[2]); end
        reset = 1'b1;
        #1;
        checks++;
        if ({valid[2], data[2], perr[2], ferr[2], brk[2], ovr[2], busy[2]} !== 14'h0) begin
            errors++; $display("FAIL midframe_reset got %b want 0",
                               {valid[2], data[2], perr[2], ferr[2], brk[2], ovr[2], busy[2]});
        end
        rxd[2] = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(12 * CPB);
        checks++;
        if ({vcnt[2] == v0, valid[2], busy[2]} !== 3'b100) begin
            errors++; $display("FAIL midframe_after cnt %0d valid %b busy %b want %0d/0/0",
                               vcnt[2], valid[2], busy[2], v0);
        end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_parity;
        test_break;
        test_glitch;
        test_enable;
        test_overrun;
        test_two_stop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
